tier2_sequencer: RTL and testbench



---
 rtl/tier2_pkg.sv | 18 +
 rtl/tier2_watchdog.sv | 33 +++
 rtl/tier2_sequencer.sv | 127 ++++++++++++
 tb/tb_tier2_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tier2_pkg.sv
// rtl/tier2_pkg.sv - state encoding and defaults shared by the Tier-2 sequencer files
package tier2_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        BUFFERING = 4'd1,
        CAL_START = 4'd2,
        CAL_WAIT  = 4'd3,
        GEN_START = 4'd4,
        GEN_WAIT  = 4'd5,
        TILE_NEXT = 4'd6,
        DONE      = 4'd7,
        ERROR     = 4'd8
    } tier2_state_t;

    localparam int TIER2_TIMEOUT_CYCLES = 50000;

endpackage

// File: rtl/tier2_watchdog.sv
// rtl/tier2_watchdog.sv - per-phase cycle counter that flags an over-long wait
module tier2_watchdog
    import tier2_pkg::*;
#(
    parameter int TIMEOUT_W      = 16,
    parameter int TIMEOUT_CYCLES = TIER2_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam logic [TIMEOUT_W-1:0] LP_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (run) begin
            r_count <= r_count + TIMEOUT_W'(1);
        end
    end

    // With TIMEOUT_CYCLES == 0 the counter may wrap freely; it can never fire.
    assign expired = (TIMEOUT_CYCLES != 0) && run && (r_count == LP_LAST);

endmodule

// File: rtl/tier2_sequencer.sv
// rtl/tier2_sequencer.sv - Tier-2 frame sequencer: buffering, truncation and codestream per tile
module tier2_sequencer
    import tier2_pkg::*;
#(
    parameter int MAX_TILES      = 4,
    parameter int TILE_W         = 2,
    parameter int TIMEOUT_W      = 16,
    parameter int TIMEOUT_CYCLES = TIER2_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rst_syn,
    input  logic              enable,
    input  logic [TILE_W-1:0] tiles_m1,
    input  logic              buffer_all_over,
    input  logic              cal_truncation_point_over,
    input  logic              codestream_generate_over,
    output logic              cal_truncation_point_start,
    output logic              codestream_generate_start,
    output logic [TILE_W-1:0] tile_index,
    output logic              busy,
    output logic              frame_done,
    output logic              timeout_err
);

    localparam logic [TILE_W-1:0] LP_LAST_TILE = TILE_W'(MAX_TILES - 1);

    tier2_state_t      r_state;
    tier2_state_t      w_next_state;
    logic [TILE_W-1:0] r_tile_index;
    logic [TILE_W-1:0] r_tile_last;
    logic [TILE_W-1:0] w_tiles_clamped;
    logic              w_waiting;
    logic              w_expired;

    assign w_tiles_clamped = (tiles_m1 > LP_LAST_TILE) ? LP_LAST_TILE : tiles_m1;

    // Wait states are never adjacent, so holding the counter clear outside them
    // guarantees it starts from zero on every entry.
    tier2_watchdog #(
        .TIMEOUT_W      (TIMEOUT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (rst_syn || !w_waiting),
        .run     (w_waiting),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_tile_index <= '0;
            r_tile_last  <= '0;
        end else begin
            r_state <= w_next_state;
            if (rst_syn) begin
                r_tile_index <= '0;
            end else if (r_state == IDLE && enable) begin
                r_tile_index <= '0;
                r_tile_last  <= w_tiles_clamped;
            end else if (r_state == TILE_NEXT && r_tile_index != r_tile_last) begin
                r_tile_index <= r_tile_index + TILE_W'(1);
            end
        end
    end

    always_comb begin
        w_next_state               = r_state;
        w_waiting                  = 1'b0;
        cal_truncation_point_start = 1'b0;
        codestream_generate_start  = 1'b0;
        frame_done                 = 1'b0;
        timeout_err                = 1'b0;
        busy                       = (r_state != IDLE);

        case (r_state)
            IDLE: begin
                if (enable) w_next_state = BUFFERING;
            end
            BUFFERING: begin
                w_waiting = 1'b1;
                if (buffer_all_over)  w_next_state = CAL_START;
                else if (w_expired)   w_next_state = ERROR;
            end
            CAL_START: begin
                cal_truncation_point_start = 1'b1;
                w_next_state               = CAL_WAIT;
            end
            CAL_WAIT: begin
                w_waiting = 1'b1;
                if (cal_truncation_point_over) w_next_state = GEN_START;
                else if (w_expired)            w_next_state = ERROR;
            end
            GEN_START: begin
                codestream_generate_start = 1'b1;
                w_next_state              = GEN_WAIT;
            end
            GEN_WAIT: begin
                w_waiting = 1'b1;
                if (codestream_generate_over)
                    w_next_state = (r_tile_index == r_tile_last) ? DONE : TILE_NEXT;
                else if (w_expired)
                    w_next_state = ERROR;
            end
            TILE_NEXT: begin
                w_next_state = BUFFERING;
            end
            DONE: begin
                frame_done   = 1'b1;
                w_next_state = IDLE;
            end
            ERROR: begin
                timeout_err = 1'b1;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        if (rst_syn) w_next_state = IDLE;
    end

    assign tile_index = r_tile_index;

endmodule

// File: tb/tb_tier2_sequencer.sv
// tb/tb_tier2_sequencer.sv - scoreboard bench for tier2_sequencer (4-tile and 3-tile instances)
module tb_tier2_sequencer;

    typedef struct packed {
        logic [31:0] cyc;
        logic [1:0]  kind;
        logic [1:0]  tile;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rst_syn = 1'b0;
    logic       enable[2];
    logic       buf_over[2];
    logic       cal_over[2];
    logic       gen_over[2];
    logic [1:0] tiles_m1[2];
    logic       cal_start[2];
    logic       gen_start[2];
    logic       busy[2];
    logic       frame_done[2];
    logic       timeout_err[2];
    logic [1:0] tile_idx[2];

    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    ev_t q0[$];
    ev_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tier2_sequencer #(.MAX_TILES(4), .TILE_W(2), .TIMEOUT_W(16), .TIMEOUT_CYCLES(8)) u_dut0 (
        .clk(clk), .rst(rst), .rst_syn(rst_syn), .enable(enable[0]), .tiles_m1(tiles_m1[0]),
        .buffer_all_over(buf_over[0]), .cal_truncation_point_over(cal_over[0]),
        .codestream_generate_over(gen_over[0]), .cal_truncation_point_start(cal_start[0]),
        .codestream_generate_start(gen_start[0]), .tile_index(tile_idx[0]), .busy(busy[0]),
        .frame_done(frame_done[0]), .timeout_err(timeout_err[0])
    );

    tier2_sequencer #(.MAX_TILES(3), .TILE_W(2), .TIMEOUT_W(16), .TIMEOUT_CYCLES(8)) u_dut1 (
        .clk(clk), .rst(rst), .rst_syn(rst_syn), .enable(enable[1]), .tiles_m1(tiles_m1[1]),
        .buffer_all_over(buf_over[1]), .cal_truncation_point_over(cal_over[1]),
        .codestream_generate_over(gen_over[1]), .cal_truncation_point_start(cal_start[1]),
        .codestream_generate_start(gen_start[1]), .tile_index(tile_idx[1]), .busy(busy[1]),
        .frame_done(frame_done[1]), .timeout_err(timeout_err[1])
    );

    function automatic logic ev_hit(input int d, input int k);
        case (k)
            0:       return cal_start[d];
            1:       return gen_start[d];
            default: return frame_done[d];
        endcase
    endfunction

    // kind 0 = cal start pulse, 1 = gen start pulse, 2 = frame_done
    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < 3; k++) begin
                    if (ev_hit(d, k) === 1'b1) begin
                        ev_t got;
                        ev_t want;
                        got.cyc  = cyc;
                        got.kind = 2'(k);
                        got.tile = tile_idx[d];
                        total++;
                        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                            bad++;
                            $display("FAIL unexpected_event dut%0d: got kind=%0d cyc=%0d tile=%0d, required no event",
                                     d, k, cyc, tile_idx[d]);
                        end else begin
                            if (d == 0) want = q0.pop_front();
                            else        want = q1.pop_front();
                            if (got !== want) begin
                                bad++;
                                $display("FAIL event dut%0d: got kind=%0d cyc=%0d tile=%0d, required kind=%0d cyc=%0d tile=%0d",
                                         d, got.kind, got.cyc, got.tile, want.kind, want.cyc, want.tile);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input int c, input int k, input int t);
        ev_t e;
        e.cyc  = c;
        e.kind = 2'(k);
        e.tile = 2'(t);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Scripted frame: enable in IDLE, each phase done on its wb/wc/wg-th wait cycle.
    // abort_kind 1 = rst_syn, 2 = async rst, applied on the first GEN_WAIT cycle of abort_tile.
    task automatic do_frame(input int d, input int n, input int wb, input int wc, input int wg,
                            input bit keep_en, input bit stray, input int abort_tile, input int abort_kind);
        enable[d] = 1'b1;
        step();
        enable[d] = keep_en;
        for (int t = 0; t < n; t++) begin
            total++;
            if (busy[d] !== 1'b1) begin
                bad++;
                $display("FAIL busy_buffering dut%0d tile%0d: got %b required 1", d, t, busy[d]);
            end
            if (stray && wb >= 2) begin
                gen_over[d] = 1'b1;
                step();
                gen_over[d] = 1'b0;
                repeat (wb - 2) step();
            end else begin
                repeat (wb - 1) step();
            end
            buf_over[d] = 1'b1;
            push(d, cyc + 1, 0, t);
            step();
            buf_over[d] = 1'b0;
            step();
            repeat (wc - 1) step();
            cal_over[d] = 1'b1;
            push(d, cyc + 1, 1, t);
            step();
            cal_over[d] = 1'b0;
            step();
            total++;
            if (tile_idx[d] !== 2'(t)) begin
                bad++;
                $display("FAIL tile_index dut%0d: got %0d required %0d", d, tile_idx[d], t);
            end
            if (t == abort_tile && abort_kind == 1) begin
                rst_syn = 1'b1;
                step();
                rst_syn = 1'b0;
                total++;
                if (busy[d] !== 1'b0 || tile_idx[d] !== 2'd0 || timeout_err[d] !== 1'b0) begin
                    bad++;
                    $display("FAIL rst_syn_abort dut%0d: got busy=%b tile=%0d err=%b required 0/0/0",
                             d, busy[d], tile_idx[d], timeout_err[d]);
                end
                step();
                return;
            end
            if (t == abort_tile && abort_kind == 2) begin
                #1 rst = 1'b0;
                #1;
                total++;
                if ({cal_start[d], gen_start[d], frame_done[d], busy[d], timeout_err[d], tile_idx[d]} !== 7'd0) begin
                    bad++;
                    $display("FAIL async_reset_outputs dut%0d: got %b required 0000000", d,
                             {cal_start[d], gen_start[d], frame_done[d], busy[d], timeout_err[d], tile_idx[d]});
                end
                @(posedge clk);
                #3 rst = 1'b1;
                step();
                total++;
                if (busy[d] !== 1'b0 || tile_idx[d] !== 2'd0) begin
                    bad++;
                    $display("FAIL after_async_reset dut%0d: got busy=%b tile=%0d required 0/0", d, busy[d], tile_idx[d]);
                end
                return;
            end
            repeat (wg - 1) step();
            gen_over[d] = 1'b1;
            if (t == n - 1) push(d, cyc + 1, 2, t);
            step();
            gen_over[d] = 1'b0;
            step();
        end
        total++;
        if (busy[d] !== 1'b0) begin
            bad++;
            $display("FAIL busy_after_frame dut%0d: got %b required 0", d, busy[d]);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if ({cal_start[d], gen_start[d], frame_done[d], busy[d], timeout_err[d], tile_idx[d]} !== 7'd0) begin
                bad++;
                $display("FAIL reset_outputs dut%0d: got %b required 0000000", d,
                         {cal_start[d], gen_start[d], frame_done[d], busy[d], timeout_err[d], tile_idx[d]});
            end
        end
        rst = 1'b1;
        step();
        for (int d = 0; d < 2; d++) begin
            total++;
            if (busy[d] !== 1'b0 || timeout_err[d] !== 1'b0) begin
                bad++;
                $display("FAIL idle_after_reset dut%0d: got busy=%b err=%b required 0/0", d, busy[d], timeout_err[d]);
            end
        end
    endtask

    task automatic test_single_tile();
        tiles_m1[0] = 2'd0;
        do_frame(0, 1, 5, 3, 4, 1'b0, 1'b0, -1, 0);
        total++;
        if (tile_idx[0] !== 2'd0 || q0.size() != 0) begin
            bad++;
            $display("FAIL single_tile_end: got tile=%0d pending=%0d required 0/0", tile_idx[0], q0.size());
        end
    endtask

    task automatic test_four_tiles();
        tiles_m1[0] = 2'd3;
        do_frame(0, 4, 3, 3, 3, 1'b0, 1'b0, -1, 0);
        total++;
        if (q0.size() != 0) begin
            bad++;
            $display("FAIL four_tiles_pending: got %0d events outstanding required 0", q0.size());
        end
    endtask

    task automatic test_clamp();
        tiles_m1[1] = 2'd3;
        do_frame(1, 3, 3, 3, 3, 1'b0, 1'b0, -1, 0);
        total++;
        if (q1.size() != 0 || timeout_err[1] !== 1'b0) begin
            bad++;
            $display("FAIL clamp_end: got pending=%0d err=%b required 0/0", q1.size(), timeout_err[1]);
        end
    endtask

    task automatic test_timeout();
        tiles_m1[0] = 2'd0;
        enable[0]   = 1'b1;
        step();
        enable[0]   = 1'b0;
        buf_over[0] = 1'b1;
        push(0, cyc + 1, 0, 0);
        step();
        buf_over[0] = 1'b0;
        step();
        repeat (7) step();
        total++;
        if (timeout_err[0] !== 1'b0) begin
            bad++;
            $display("FAIL timeout_early: got %b required 0 on 8th CAL_WAIT cycle", timeout_err[0]);
        end
        step();
        total++;
        if (timeout_err[0] !== 1'b1) begin
            bad++;
            $display("FAIL timeout_entry: got %b required 1", timeout_err[0]);
        end
        repeat (5) step();
        cal_over[0] = 1'b1;
        step();
        cal_over[0] = 1'b0;
        step();
        total++;
        if (timeout_err[0] !== 1'b1 || busy[0] !== 1'b1) begin
            bad++;
            $display("FAIL timeout_held: got err=%b busy=%b required 1/1", timeout_err[0], busy[0]);
        end
        rst_syn = 1'b1;
        step();
        rst_syn = 1'b0;
        total++;
        if (timeout_err[0] !== 1'b0 || busy[0] !== 1'b0 || tile_idx[0] !== 2'd0) begin
            bad++;
            $display("FAIL timeout_recover: got err=%b busy=%b tile=%0d required 0/0/0",
                     timeout_err[0], busy[0], tile_idx[0]);
        end
        total++;
        if (q0.size() != 0) begin
            bad++;
            $display("FAIL timeout_pending: got %0d required 0", q0.size());
        end
    endtask

    task automatic test_race();
        tiles_m1[0] = 2'd0;
        do_frame(0, 1, 8, 8, 8, 1'b0, 1'b0, -1, 0);
        total++;
        if (timeout_err[0] !== 1'b0 || q0.size() != 0) begin
            bad++;
            $display("FAIL race: got err=%b pending=%0d required 0/0", timeout_err[0], q0.size());
        end
    endtask

    task automatic test_stray_pulse();
        tiles_m1[0] = 2'd1;
        do_frame(0, 2, 3, 3, 3, 1'b0, 1'b1, -1, 0);
        total++;
        if (q0.size() != 0) begin
            bad++;
            $display("FAIL stray_pending: got %0d required 0", q0.size());
        end
    endtask

    task automatic test_syn_abort();
        tiles_m1[0] = 2'd3;
        do_frame(0, 4, 2, 2, 2, 1'b0, 1'b0, 2, 1);
        total++;
        if (q0.size() != 0 || busy[0] !== 1'b0) begin
            bad++;
            $display("FAIL syn_abort_end: got pending=%0d busy=%b required 0/0", q0.size(), busy[0]);
        end
    endtask

    task automatic test_async_abort();
        tiles_m1[0] = 2'd1;
        do_frame(0, 2, 2, 2, 2, 1'b0, 1'b0, 1, 2);
        step();
        total++;
        if (q0.size() != 0 || busy[0] !== 1'b0) begin
            bad++;
            $display("FAIL async_abort_end: got pending=%0d busy=%b required 0/0", q0.size(), busy[0]);
        end
    endtask

    task automatic test_back_to_back();
        tiles_m1[0] = 2'd0;
        do_frame(0, 1, 2, 2, 2, 1'b1, 1'b0, -1, 0);
        do_frame(0, 1, 2, 2, 2, 1'b0, 1'b0, -1, 0);
        total++;
        if (q0.size() != 0) begin
            bad++;
            $display("FAIL back_to_back_pending: got %0d required 0", q0.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1, "time budget exceeded");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            enable[d]   = 1'b0;
            buf_over[d] = 1'b0;
            cal_over[d] = 1'b0;
            gen_over[d] = 1'b0;
            tiles_m1[d] = 2'd0;
        end
        test_reset();
        test_single_tile();
        test_four_tiles();
        test_clamp();
        test_timeout();
        test_race();
        test_stray_pulse();
        test_syn_abort();
        test_async_abort();
        test_back_to_back();
        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
